// File: rtl/dragon_move_scheduler.sv
// Dragon movement sequencer: triggers the target selector once every MOVE_PERIOD frames and steps one cell toward its target.
// Optional: define DRAGON_DIAGONAL_MOVE_EN to step x and y together in the same cycle.
module dragon_move_scheduler #(
    parameter int         MOVE_PERIOD = 8,
    parameter int         STUN_FRAMES = 32,
    parameter logic [7:0] START_POS   = 8'h66,
    parameter int         Y_MAX       = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic       dragon_hurt,
    input  logic [7:0] target_pos,
    input  logic [7:0] player_pos,
    input  logic [7:0] sheep_pos,
    output logic       trigger,
    output logic [7:0] dragon_pos,
    output logic [1:0] dragon_dir,
    output logic       moving,
    output logic       target_reached_player,
    output logic       target_reached_sheep,
    output logic       stunned
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] TRIG  = 3'd1;
    localparam logic [2:0] WAIT1 = 3'd2;
    localparam logic [2:0] WAIT2 = 3'd3;
    localparam logic [2:0] STEP  = 3'd4;
    localparam logic [2:0] STUN  = 3'd5;

    localparam int FCW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int SCW = $clog2(STUN_FRAMES + 1);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(MOVE_PERIOD - 1);
    localparam logic [SCW-1:0] STUN_LOAD  = SCW'(STUN_FRAMES);
    localparam logic [3:0]     Y_LIM      = 4'(Y_MAX);

    logic [2:0]     state_reg, state_next;
    logic [FCW-1:0] frame_cnt_reg, frame_cnt_next;
    logic [SCW-1:0] stun_cnt_reg, stun_cnt_next;
    logic [7:0]     pos_reg, pos_next;
    logic [1:0]     dir_reg, dir_next;
    logic           moving_reg, moving_next;

    logic [3:0] cur_x, cur_y, tgt_x, tgt_y, step_x, step_y;
    logic [1:0] step_dir;
    logic       step_valid;

    assign cur_x = pos_reg[7:4];
    assign cur_y = pos_reg[3:0];
    assign tgt_x = target_pos[7:4];
    // Targets below the playfield are clamped so the dragon never leaves it.
    assign tgt_y = (target_pos[3:0] > Y_LIM) ? Y_LIM : target_pos[3:0];

    always_comb begin
        step_x     = cur_x;
        step_y     = cur_y;
        step_dir   = dir_reg;
        step_valid = 1'b0;
`ifdef DRAGON_DIAGONAL_MOVE_EN
        if (cur_x != tgt_x) begin
            step_x     = (cur_x < tgt_x) ? cur_x + 4'd1 : cur_x - 4'd1;
            step_dir   = (cur_x < tgt_x) ? 2'd3 : 2'd2;
            step_valid = 1'b1;
        end
        if (cur_y != tgt_y) begin
            step_y     = (cur_y < tgt_y) ? cur_y + 4'd1 : cur_y - 4'd1;
            step_valid = 1'b1;
            if (cur_x == tgt_x) begin
                step_dir = (cur_y < tgt_y) ? 2'd1 : 2'd0;
            end
        end
`else
        if (cur_x != tgt_x) begin
            step_x     = (cur_x < tgt_x) ? cur_x + 4'd1 : cur_x - 4'd1;
            step_dir   = (cur_x < tgt_x) ? 2'd3 : 2'd2;
            step_valid = 1'b1;
        end else if (cur_y != tgt_y) begin
            step_y     = (cur_y < tgt_y) ? cur_y + 4'd1 : cur_y - 4'd1;
            step_dir   = (cur_y < tgt_y) ? 2'd1 : 2'd0;
            step_valid = 1'b1;
        end
`endif
    end

    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        stun_cnt_next  = stun_cnt_reg;
        pos_next       = pos_reg;
        dir_next       = dir_reg;
        moving_next    = 1'b0;
        // A hit pre-empts everything, including a step about to be committed.
        if (dragon_hurt) begin
            state_next     = STUN;
            stun_cnt_next  = STUN_LOAD;
            frame_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable && frame_tick) begin
                        if (frame_cnt_reg == FRAME_LAST) begin
                            frame_cnt_next = '0;
                            state_next     = TRIG;
                        end else begin
                            frame_cnt_next = frame_cnt_reg + FCW'(1);
                        end
                    end
                end
                TRIG:  state_next = WAIT1;
                WAIT1: state_next = WAIT2;
                WAIT2: state_next = STEP;
                STEP: begin
                    state_next = IDLE;
                    if (step_valid) begin
                        pos_next    = {step_x, step_y};
                        dir_next    = step_dir;
                        moving_next = 1'b1;
                    end
                end
                STUN: begin
                    if (frame_tick) begin
                        stun_cnt_next = stun_cnt_reg - SCW'(1);
                        if (stun_cnt_reg == SCW'(1)) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            frame_cnt_reg <= '0;
            stun_cnt_reg  <= '0;
            pos_reg       <= START_POS;
            dir_reg       <= 2'd0;
            moving_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            stun_cnt_reg  <= stun_cnt_next;
            pos_reg       <= pos_next;
            dir_reg       <= dir_next;
            moving_reg    <= moving_next;
        end
    end

    logic [7:0] watch_pos [2];
    assign watch_pos[0] = player_pos;
    assign watch_pos[1] = sheep_pos;

    // Flags track the registered position; they read 0 for every cycle spent stunned.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_reached
            logic hit_reg;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    hit_reg <= 1'b0;
                end else begin
                    hit_reg <= (state_next != STUN) && (pos_reg == watch_pos[gi]);
                end
            end
        end
    endgenerate

    assign target_reached_player = g_reached[0].hit_reg;
    assign target_reached_sheep  = g_reached[1].hit_reg;
    assign trigger               = (state_reg == TRIG);
    assign stunned               = (state_reg == STUN);
    assign dragon_pos            = pos_reg;
    assign dragon_dir            = dir_reg;
    assign moving                = moving_reg;

endmodule

// File: tb/tb_dragon_move_scheduler.sv
// Scoreboard bench for dragon_move_scheduler: a frame-level reference model queues expected triggers and moves.
module tb_dragon_move_scheduler;

    localparam int         MOVE_PERIOD = 8;
    localparam int         STUN_FRAMES = 32;
    localparam int         Y_MAX       = 11;
    localparam logic [7:0] START_POS   = 8'h66;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       frame_tick = 1'b0;
    logic       dragon_hurt = 1'b0;
    logic [7:0] target_pos = 8'h00;
    logic [7:0] player_pos = 8'hff;
    logic [7:0] sheep_pos = 8'hff;
    logic       trigger;
    logic [7:0] dragon_pos;
    logic [1:0] dragon_dir;
    logic       moving;
    logic       target_reached_player;
    logic       target_reached_sheep;
    logic       stunned;

    dragon_move_scheduler #(
        .MOVE_PERIOD(MOVE_PERIOD),
        .STUN_FRAMES(STUN_FRAMES),
        .START_POS(START_POS),
        .Y_MAX(Y_MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .frame_tick(frame_tick),
        .dragon_hurt(dragon_hurt),
        .target_pos(target_pos),
        .player_pos(player_pos),
        .sheep_pos(sheep_pos),
        .trigger(trigger),
        .dragon_pos(dragon_pos),
        .dragon_dir(dragon_dir),
        .moving(moving),
        .target_reached_player(target_reached_player),
        .target_reached_sheep(target_reached_sheep),
        .stunned(stunned)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] pos;
        logic [1:0] dir;
    } move_t;

    int    n_total = 0;
    int    n_bad = 0;
    int    q_trig[$];
    move_t q_move[$];
    int    cyc = 0;
    int    trig_seen = 0;
    int    move_seen = 0;

    // Reference model: frames counted toward the next move, cycles since the
    // trigger (-1 = waiting for frames), frames of stun left.
    int m_x, m_y, m_dir, m_frames, m_phase, m_stun_left;
    bit m_stunned, m_rp, m_rs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_x = START_POS[7:4];
        m_y = START_POS[3:0];
        m_dir = 0;
        m_frames = 0;
        m_phase = -1;
        m_stun_left = 0;
        m_stunned = 1'b0;
        m_rp = 1'b0;
        m_rs = 1'b0;
        q_trig.delete();
        q_move.delete();
    endfunction

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic void model_step();
        int    tx, ty, dx, dy;
        move_t e;
        logic [7:0] p;
        tx = int'(target_pos[7:4]);
        ty = int'(target_pos[3:0]);
        if (ty > Y_MAX) ty = Y_MAX;
        dx = sgn(tx - m_x);
        dy = sgn(ty - m_y);
`ifndef DRAGON_DIAGONAL_MOVE_EN
        if (dx != 0) dy = 0;
`endif
        if (dx != 0) m_dir = (dx > 0) ? 3 : 2;
        else if (dy != 0) m_dir = (dy > 0) ? 1 : 0;
        if (dx != 0 || dy != 0) begin
            m_x = m_x + dx;
            m_y = m_y + dy;
            p = {m_x[3:0], m_y[3:0]};
            e.cyc = cyc;
            e.pos = p;
            e.dir = m_dir[1:0];
            q_move.push_back(e);
        end
    endfunction

    always @(posedge clk) begin : model
        logic [7:0] pre_pos;
        cyc++;
        if (!reset) begin
            model_reset();
        end else begin
            pre_pos = {m_x[3:0], m_y[3:0]};
            if (dragon_hurt) begin
                m_stunned = 1'b1;
                m_stun_left = STUN_FRAMES;
                m_phase = -1;
                m_frames = 0;
            end else if (m_stunned) begin
                if (frame_tick) begin
                    m_stun_left--;
                    if (m_stun_left == 0) m_stunned = 1'b0;
                end
            end else if (m_phase == 3) begin
                model_step();
                m_phase = -1;
            end else if (m_phase >= 0) begin
                m_phase++;
            end else if (enable && frame_tick) begin
                if (m_frames == MOVE_PERIOD - 1) begin
                    m_frames = 0;
                    m_phase = 0;
                    q_trig.push_back(cyc);
                end else begin
                    m_frames++;
                end
            end
            m_rp = !m_stunned && (pre_pos == player_pos);
            m_rs = !m_stunned && (pre_pos == sheep_pos);
        end
    end

    always @(negedge clk) begin : monitor
        move_t      e;
        logic [7:0] mp;
        if (reset) begin
            if (trigger === 1'b1) begin
                trig_seen++;
                if (q_trig.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL trigger_unexpected: got trigger=1 expected no trigger (cycle %0d)", cyc);
                end else begin
                    check("trigger_cycle", cyc, q_trig.pop_front());
                end
            end
            if (moving === 1'b1) begin
                move_seen++;
                if (q_move.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL move_unexpected: got moving=1 pos=%0h expected no move (cycle %0d)", dragon_pos, cyc);
                end else begin
                    e = q_move.pop_front();
                    check("move_cycle", cyc, e.cyc);
                    check("move_pos", dragon_pos, e.pos);
                    check("move_dir", dragon_dir, e.dir);
                end
            end
            mp = {m_x[3:0], m_y[3:0]};
            check("pos", dragon_pos, mp);
            check("dir", dragon_dir, m_dir);
            check("stunned", stunned, m_stunned);
            check("reached_player", target_reached_player, m_rp);
            check("reached_sheep", target_reached_sheep, m_rs);
        end
    end

    task automatic tick(input int gap);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(5);
    endtask

    initial begin : stim
        int t0, m0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pos", dragon_pos, 8'h66);
        check("rst_dir", dragon_dir, 2'd0);
        check("rst_trigger", trigger, 1'b0);
        check("rst_moving", moving, 1'b0);
        check("rst_stunned", stunned, 1'b0);
        check("rst_reached_p", target_reached_player, 1'b0);
        check("rst_reached_s", target_reached_sheep, 1'b0);
        #1 reset = 1'b1;

        // 8 ticks give exactly one trigger, one cycle after the 8th.
        enable = 1'b1;
        target_pos = 8'h94;
        player_pos = 8'h00;
        sheep_pos = 8'h96;
        t0 = trig_seen;
        ticks(7);
        check("no_early_trigger", trig_seen, t0);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        #1;
        check("trigger_after_8th", trig_seen, t0 + 1);
        repeat (5) @(negedge clk);
        ticks(16);
        check("pos_after_3", dragon_pos, 8'h96);
        check("dir_after_3", dragon_dir, 2'd3);
        ticks(16);
        check("pos_after_5", dragon_pos, 8'h94);
        check("dir_after_5", dragon_dir, 2'd0);

        // Walk to 3A, then aim below the playfield: clamps at y=11.
        target_pos = 8'h3a;
        for (int i = 0; i < 20 && !(m_x == 3 && m_y == 10); i++) ticks(8);
        check("reach_3a", dragon_pos, 8'h3a);
        target_pos = 8'h3f;
        ticks(8);
        check("clamp_step", dragon_pos, 8'h3b);
        m0 = move_seen;
        ticks(16);
        check("clamp_hold", dragon_pos, 8'h3b);
        check("clamp_no_moving", move_seen, m0);

        // Hurt during WAIT2 discards the step.
        player_pos = 8'h3b;
        ticks(7);
        target_pos = 8'h00;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        dragon_hurt = 1'b1;
        @(negedge clk);
        dragon_hurt = 1'b0;
        #1;
        check("hurt_stunned", stunned, 1'b1);
        check("hurt_no_step", dragon_pos, 8'h3b);
        check("stun_reached_forced0", target_reached_player, 1'b0);
        for (int i = 0; i < 10; i++) tick(1);
        @(negedge clk);
        dragon_hurt = 1'b1;
        @(negedge clk);
        dragon_hurt = 1'b0;
        for (int i = 0; i < 31; i++) tick(1);
        #1;
        check("stun_after_31", stunned, 1'b1);
        tick(0);
        #1;
        check("stun_released", stunned, 1'b0);
        @(negedge clk);
        #1;
        check("reached_after_stun", target_reached_player, 1'b1);

        // Asynchronous reset in the middle of a STEP cycle.
        ticks(7);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_pos", dragon_pos, 8'h66);
        check("async_trigger", trigger, 1'b0);
        check("async_stunned", stunned, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;

        target_pos = 8'h88;
        ticks(8);
`ifdef DRAGON_DIAGONAL_MOVE_EN
        check("diag_first", dragon_pos, 8'h77);
        check("diag_first_dir", dragon_dir, 2'd3);
        ticks(8);
        check("diag_second", dragon_pos, 8'h88);
        check("diag_second_dir", dragon_dir, 2'd3);
`else
        check("xfirst_first", dragon_pos, 8'h76);
        check("xfirst_first_dir", dragon_dir, 2'd3);
        ticks(8);
        check("xfirst_second", dragon_pos, 8'h86);
        check("xfirst_second_dir", dragon_dir, 2'd3);
`endif

        // Randomized traffic checked by the monitor.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            frame_tick = ($urandom_range(0, 2) == 0);
            dragon_hurt = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0) target_pos = 8'($urandom);
            if ((i % 16) == 0) begin
                player_pos = ($urandom_range(0, 1) == 0) ? {m_x[3:0], m_y[3:0]} : 8'($urandom);
                sheep_pos = ($urandom_range(0, 2) == 0) ? {m_x[3:0], m_y[3:0]} : 8'($urandom);
            end
        end
        @(negedge clk);
        frame_tick = 1'b0;
        dragon_hurt = 1'b0;
        repeat (10) @(negedge clk);
        check("trig_queue_drained", q_trig.size(), 0);
        check("move_queue_drained", q_move.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
